// File: rtl/ring_rotate_ctrl_pkg.sv
// ring_rotate_ctrl_pkg: shared sizes, command/state enums and preset pattern for the ring controller
package ring_rotate_ctrl_pkg;
  localparam int DEPTH = 10;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int OFF_W = $clog2(DEPTH);
  localparam int PRESET_STEP = 5;
  typedef enum logic [1:0] {OP_NOP, OP_PRESET, OP_ROTATE, OP_RSVD} ring_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} ring_state_e;
  function automatic logic [WIDTH-1:0] preset_val(input int i);
    int v;
    v = PRESET_STEP * (i + 1);
    return v[WIDTH-1:0];
  endfunction
endpackage

// File: rtl/ring_rotate_ctrl_if.sv
// ring_rotate_ctrl_if: command handshake and status bundle between a command source and the ring controller
//   master: drives cmd_valid/cmd_op/cmd_count/stop, observes ready, busy, done, aborted, head_data, offset
//   slave:  the controller side of the same signals
interface ring_rotate_ctrl_if;
  import ring_rotate_ctrl_pkg::*;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             stop;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] head_data;
  logic [OFF_W-1:0] offset;
  modport master (output cmd_valid, cmd_op, cmd_count, stop,
                  input  cmd_ready, busy, done, aborted, head_data, offset);
  modport slave  (input  cmd_valid, cmd_op, cmd_count, stop,
                  output cmd_ready, busy, done, aborted, head_data, offset);
endinterface

// File: rtl/ring_rotate_ctrl_store.sv
// ring_store: DEPTH x WIDTH circular register with preset load and single-step rotate
//   clk, reset (sync, active-low, loads the preset pattern)
//   i_load_en: load preset pattern (wins over shift); i_shift_en: stage i+1 <- stage i, stage 0 <- last
//   o_head: stage 0
module ring_store
  import ring_rotate_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_en,
  input  logic             i_shift_en,
  output logic [WIDTH-1:0] o_head
);
  logic [WIDTH-1:0] r_ring [DEPTH];
  always_ff @(posedge clk) begin
    if (!reset || i_load_en) begin
      for (int i = 0; i < DEPTH; i++) r_ring[i] <= preset_val(i);
    end else if (i_shift_en) begin
      r_ring[0] <= r_ring[DEPTH-1];
      for (int i = 1; i < DEPTH; i++) r_ring[i] <= r_ring[i-1];
    end
  end
  assign o_head = r_ring[0];
endmodule

// File: rtl/ring_rotate_ctrl.sv
// ring_rotate_ctrl: command FSM that presets/rotates the ring and tracks the cumulative rotation offset
//   clk, reset (sync, active-low)
//   bus (slave): cmd_valid/cmd_ready handshake, cmd_op, cmd_count, stop in; busy, done, aborted, head_data, offset out
module ring_rotate_ctrl
  import ring_rotate_ctrl_pkg::*;
(
  input logic          clk,
  input logic          reset,
  ring_rotate_ctrl_if.slave bus
);
  ring_state_e      r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [OFF_W-1:0] r_offset;
  logic             r_aborted;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_head;
  assign w_accept = bus.cmd_valid && r_state == S_IDLE;
  assign w_load   = w_accept && bus.cmd_op == OP_PRESET;
  assign w_shift  = r_state == S_ROTATE;
  ring_store u_store (
    .clk        (clk),
    .reset      (reset),
    .i_load_en  (w_load),
    .i_shift_en (w_shift),
    .o_head     (w_head)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_offset    <= '0;
      r_aborted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_aborted <= 1'b0;
          if (w_accept && bus.cmd_op == OP_PRESET) begin
            r_offset <= '0;
            r_state  <= S_DONE;
          end else if (w_accept && bus.cmd_op == OP_ROTATE) begin
            r_remaining <= bus.cmd_count;
            r_state     <= bus.cmd_count == '0 ? S_DONE : S_ROTATE;
          end
        end
        S_ROTATE: begin
          r_offset    <= r_offset == OFF_W'(DEPTH - 1) ? '0 : r_offset + OFF_W'(1);
          r_remaining <= r_remaining - CNT_W'(1);
          // the shift of a stop cycle still happens; stop on the last step still flags aborted
          if (bus.stop || r_remaining == CNT_W'(1)) begin
            r_aborted <= bus.stop;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = r_state == S_IDLE;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.done      = r_state == S_DONE;
  assign bus.aborted   = r_aborted;
  assign bus.head_data = w_head;
  assign bus.offset    = r_offset;
endmodule

// File: tb/tb_ring_rotate_ctrl.sv
// tb_ring_rotate_ctrl: randomized and directed checks of the ring controller against an offset-based model
module tb_ring_rotate_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   m_off = 0;
  ring_rotate_ctrl_if bus();
  ring_rotate_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_head(input int o);
    int idx;
    idx = (10 - (o % 10)) % 10;
    return 8'(5 * (idx + 1));
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input int cnt, input int stop_at);
    if (op == 2'd1) return 1;
    if (op == 2'd2) return cnt == 0 ? 1 : (stop_at > 0 ? stop_at : cnt) + 1;
    return -1;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input int cnt, input int stop_at, input int limit,
                         output int lat, output logic ab);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = 8'(cnt);
    bus.stop      = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = -1;
    ab  = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (bus.done) begin
        lat = k;
        ab  = bus.aborted;
        break;
      end
      bus.stop = (k == stop_at);
      @(negedge clk);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_off = 0;
    total += 5;
    if (bus.head_data !== 8'd5) begin bad++; $display("FAIL reset_head got=%0d want=5", bus.head_data); end
    if (bus.offset !== 4'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", bus.offset); end
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
  endtask

  task automatic test_rotate_one;
    int lat; logic ab;
    run_cmd(2'd2, 1, 0, 20, lat, ab);
    m_off = (m_off + 1) % 10;
    total += 6;
    if (lat !== 2) begin bad++; $display("FAIL rot1_latency got=%0d want=2", lat); end
    if (ab !== 1'b0) begin bad++; $display("FAIL rot1_aborted got=%b want=0", ab); end
    if (bus.head_data !== 8'd50) begin bad++; $display("FAIL rot1_head got=%0d want=50", bus.head_data); end
    if (bus.offset !== 4'(m_off)) begin bad++; $display("FAIL rot1_offset got=%0d want=%0d", bus.offset, m_off); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rot1_busy_done got=%b want=1", bus.busy); end
    @(negedge clk);
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rot1_ready_after got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic test_full_turn;
    int lat; logic ab;
    logic [7:0] h0;
    logic [3:0] o0;
    h0 = exp_head(m_off);
    o0 = 4'(m_off);
    run_cmd(2'd2, 10, 0, 30, lat, ab);
    total += 3;
    if (lat !== 11) begin bad++; $display("FAIL rot10_latency got=%0d want=11", lat); end
    if (bus.head_data !== h0) begin bad++; $display("FAIL rot10_head got=%0d want=%0d", bus.head_data, h0); end
    if (bus.offset !== o0) begin bad++; $display("FAIL rot10_offset got=%0d want=%0d", bus.offset, o0); end
    run_cmd(2'd2, 0, 0, 10, lat, ab);
    total += 3;
    if (lat !== 1) begin bad++; $display("FAIL rot0_latency got=%0d want=1", lat); end
    if (bus.head_data !== h0) begin bad++; $display("FAIL rot0_head got=%0d want=%0d", bus.head_data, h0); end
    if (bus.offset !== o0) begin bad++; $display("FAIL rot0_offset got=%0d want=%0d", bus.offset, o0); end
  endtask

  task automatic test_rotate_preset;
    int lat; logic ab;
    run_cmd(2'd1, 0, 0, 10, lat, ab);
    m_off = 0;
    run_cmd(2'd2, 13, 0, 30, lat, ab);
    m_off = 3;
    total += 3;
    if (lat !== 14) begin bad++; $display("FAIL rot13_latency got=%0d want=14", lat); end
    if (bus.offset !== 4'd3) begin bad++; $display("FAIL rot13_offset got=%0d want=3", bus.offset); end
    if (bus.head_data !== 8'd40) begin bad++; $display("FAIL rot13_head got=%0d want=40", bus.head_data); end
    run_cmd(2'd1, 0, 0, 10, lat, ab);
    m_off = 0;
    total += 3;
    if (lat !== 1) begin bad++; $display("FAIL preset_latency got=%0d want=1", lat); end
    if (bus.head_data !== 8'd5) begin bad++; $display("FAIL preset_head got=%0d want=5", bus.head_data); end
    if (bus.offset !== 4'd0) begin bad++; $display("FAIL preset_offset got=%0d want=0", bus.offset); end
  endtask

  task automatic test_stop;
    int lat; logic ab;
    run_cmd(2'd2, 200, 4, 260, lat, ab);
    m_off = (m_off + 4) % 10;
    total += 4;
    if (lat !== 5) begin bad++; $display("FAIL stop_latency got=%0d want=5", lat); end
    if (ab !== 1'b1) begin bad++; $display("FAIL stop_aborted got=%b want=1", ab); end
    if (bus.offset !== 4'd4) begin bad++; $display("FAIL stop_offset got=%0d want=4", bus.offset); end
    if (bus.head_data !== 8'd35) begin bad++; $display("FAIL stop_head got=%0d want=35", bus.head_data); end
  endtask

  task automatic test_nop;
    int lat; logic ab;
    for (int j = 0; j < 2; j++) begin
      run_cmd(j == 0 ? 2'd0 : 2'd3, 5, 0, 6, lat, ab);
      total += 3;
      if (lat !== -1) begin bad++; $display("FAIL nop_done_seen got=%0d want=-1", lat); end
      if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b want=1", bus.cmd_ready); end
      if (bus.offset !== 4'(m_off)) begin bad++; $display("FAIL nop_offset got=%0d want=%0d", bus.offset, m_off); end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_count = 8'd8;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_off = 0;
    total += 5;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", bus.cmd_ready); end
    if (bus.head_data !== 8'd5) begin bad++; $display("FAIL rstmid_head got=%0d want=5", bus.head_data); end
    if (bus.offset !== 4'd0) begin bad++; $display("FAIL rstmid_offset got=%0d want=0", bus.offset); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rstmid_late_done got=%0d want=0", seen); end
  endtask

  task automatic test_random;
    int lat, cnt, stop_at, want;
    logic ab;
    logic [1:0] op;
    for (int r = 0; r < 30; r++) begin
      op = 2'($urandom_range(0, 3));
      cnt = int'($urandom_range(0, 25));
      stop_at = (op == 2'd2 && cnt > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, cnt)) : 0;
      want = exp_lat(op, cnt, stop_at);
      run_cmd(op, cnt, stop_at, want < 0 ? 4 : want + 5, lat, ab);
      if (op == 2'd1) m_off = 0;
      else if (op == 2'd2) m_off = (m_off + (stop_at > 0 ? stop_at : cnt)) % 10;
      total += 4;
      if (lat !== want) begin bad++; $display("FAIL rand_latency op=%0d cnt=%0d stop=%0d got=%0d want=%0d", op, cnt, stop_at, lat, want); end
      if (ab !== (stop_at > 0)) begin bad++; $display("FAIL rand_aborted op=%0d cnt=%0d stop=%0d got=%b", op, cnt, stop_at, ab); end
      if (bus.offset !== 4'(m_off)) begin bad++; $display("FAIL rand_offset got=%0d want=%0d", bus.offset, m_off); end
      if (bus.head_data !== exp_head(m_off)) begin bad++; $display("FAIL rand_head got=%0d want=%0d", bus.head_data, exp_head(m_off)); end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_count = 8'd0;
    bus.stop      = 1'b0;
    test_reset();
    test_rotate_one();
    test_full_turn();
    test_rotate_preset();
    test_stop();
    test_nop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ring_rotate_ctrl.md
# ring_rotate_ctrl

Command-driven controller for the 10-stage circular data register: it presets the ring to its fixed pattern, rotates it by a requested number of steps, and reports the head value and the cumulative rotation offset. It sits between a command source (valid/ready) and the ring storage, and is the only block permitted to shift or load the ring.

## Interface
- `DEPTH`, 10: number of ring stages (≥2).
- `WIDTH`, 8: bits per stage.
- `CNT_W`, 8: width of the rotate-count field.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  0 NOP, 1 PRESET, 2 ROTATE, 3 reserved (treated as NOP).
- `cmd_count`  in  CNT_W  rotate step count (ROTATE only).
- `stop`  in  1  request early termination of a ROTATE.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  valid with `done`: ROTATE ended by `stop`.
- `head_data`  out  WIDTH  current value of stage 0.
- `offset`  out  $clog2(DEPTH)  cumulative rotation modulo DEPTH.

## Operation
- Ring shift: stage i+1 ← stage i, stage 0 ← stage DEPTH-1 (one step = one shift).
- Preset pattern: stage i = 5·(i+1), truncated to WIDTH (DEPTH=10: 5,10,…,50).
- States: IDLE, ROTATE, DONE.
- IDLE: `cmd_ready`=1. Handshake = `cmd_valid && cmd_ready`.
  - PRESET accepted: load pattern, clear `offset` on the same edge; → DONE.
  - ROTATE, count=0: no shift; → DONE.
  - ROTATE, count>0: latch count into `remaining`; → ROTATE.
  - NOP/reserved: consumed, no effect, stays IDLE, no `done`.
- ROTATE: every cycle one shift, `offset` += 1 (DEPTH-1 wraps to 0), `remaining` -= 1; when the shift that brings `remaining` to 0 occurs → DONE.
- `stop` sampled high in ROTATE: the shift of that cycle still happens, then → DONE with `aborted`=1. `stop` in IDLE/DONE ignored.
- DONE: `done`=1 for one cycle, `aborted` valid; → IDLE.
- `busy` = state ≠ IDLE. `cmd_ready` = state == IDLE.
- Reset (any state, mid-rotation included): state IDLE, ring = preset pattern, `offset`=0, `remaining`=0, `done`=0, `aborted`=0, `busy`=0, `cmd_ready`=1 from the first cycle after reset deasserts; `head_data` = 5.

## Timing
- Command accepted in cycle T.
- PRESET, ROTATE 0: `done` at T+1, `cmd_ready` again at T+2.
- ROTATE n>0: shifts on edges ending cycles T+1…T+n, `done` at T+n+1, `cmd_ready` at T+n+2.
- `stop` high in cycle T+k (1≤k≤n): k shifts total, `done`+`aborted` at T+k+1.
- `head_data`/`offset` are registered ring/offset state, updated on the shift edge; no combinational path from command inputs.
- ROTATE of n ≡ 0 mod DEPTH leaves ring and `offset` unchanged at completion.

## Structure
- Shared package: `ring_op_e` (NOP, PRESET, ROTATE, RSVD), `ring_state_e`, preset-step constant (5), and a preset-value function.
- Sub-module `ring_store`: DEPTH×WIDTH storage with `load_en` (preset) and `shift_en` inputs and a `head` output; the controller owns the FSM, `remaining`, and `offset`.

## Test plan
- Reset, then idle → `head_data`=5, `offset`=0, `cmd_ready`=1, `busy`=0.
- ROTATE 1 → one shift; `head_data`=50, `offset`=1, `done` exactly 2 cycles after accept.
- ROTATE 10 → `head_data`=5, `offset`=0, `done` at T+11; ROTATE 0 → `done` at T+1, no change.
- ROTATE 13 from offset 0 → `offset`=3, `head_data`=40; then PRESET → `head_data`=5, `offset`=0.
- ROTATE 200, `stop` at T+4 → 4 shifts, `offset`=4, `head_data`=35, `done`+`aborted` at T+5.
- Reset asserted at T+3 of ROTATE 8 → next cycle IDLE, `head_data`=5, `offset`=0, no `done` pulse.
